// File: rtl/zero_chain_detect_if.sv
// Operand/status bundle between the ALU result bus and the zero-chain detector.
// The master drives framed operand words; the slave returns the Z flag and status.
interface zero_chain_detect_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 4
);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  // operand side
  logic [WIDTH-1:0] a;
  logic             valid;
  logic             first;
  logic             last;

  // status side
  logic             busy;
  logic             done;
  logic             zero;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] nz_cnt;
  logic             err;

  modport master (
    output a, valid, first, last,
    input  busy, done, zero, word_cnt, nz_cnt, err
  );

  modport slave (
    input  a, valid, first, last,
    output busy, done, zero, word_cnt, nz_cnt, err
  );
endinterface

// File: rtl/zero_chain_detect.sv
// Framed multi-word all-zero detector. Accepts one operand word per valid cycle,
// accumulates zero / word count / non-zero count across a first..last frame and
// publishes them as registered flags with one-cycle done and err pulses.
module zero_chain_detect #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 4,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  zero_chain_detect_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // The word test is split into 4-bit chunk flags so wide operands reduce as a
  // shallow tree; the top chunk is zero-padded when WIDTH is not a multiple of 4.
  localparam int NCHUNK = (WIDTH + 3) / 4;

  logic [NCHUNK*4-1:0] a_pad;
  logic [NCHUNK-1:0]   chunk_z;
  logic                wz;

  state_t              state_reg,    state_next;
  logic                acc_z_reg,    acc_z_next;
  logic [CNT_W-1:0]    acc_cnt_reg,  acc_cnt_next;
  logic [CNT_W-1:0]    acc_nz_reg,   acc_nz_next;
  logic                zero_reg,     zero_next;
  logic [CNT_W-1:0]    word_cnt_reg, word_cnt_next;
  logic [CNT_W-1:0]    nz_cnt_reg,   nz_cnt_next;
  logic                done_reg,     done_next;
  logic                err_reg,      err_next;

  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    nz_inc;
  logic [CNT_W-1:0]    wnz_cnt;

  // Zero-extend the operand to a whole number of chunks.
  always_comb begin
    a_pad             = '0;
    a_pad[WIDTH-1:0]  = bus.a;
  end

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign chunk_z[gi] = (a_pad[gi*4 +: 4] == 4'd0);
  end

  assign wz      = &chunk_z;
  assign wnz_cnt = wz ? '0 : CNT_W'(1);
  // Position of the incoming word within the open frame, and updated non-zero tally.
  assign cnt_inc = acc_cnt_reg + CNT_W'(1);
  assign nz_inc  = acc_nz_reg + wnz_cnt;

  // State register: the only FSM storage; reset discards any open frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: a frame opens on first without last, and closes on last,
  // on overflow, or is replaced when a new first arrives mid-frame.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.valid && bus.first && !bus.last) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.valid) begin
          if (bus.first) begin
            state_next = bus.last ? IDLE : ACCUM;
          end else if (bus.last || (cnt_inc == CNT_W'(MAX_WORDS))) begin
            state_next = IDLE;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/accumulator next values: result registers change only on done,
  // pulses default low every cycle.
  always_comb begin
    acc_z_next    = acc_z_reg;
    acc_cnt_next  = acc_cnt_reg;
    acc_nz_next   = acc_nz_reg;
    zero_next     = zero_reg;
    word_cnt_next = word_cnt_reg;
    nz_cnt_next   = nz_cnt_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    if (bus.valid) begin
      if (bus.first) begin
        // A first while a frame is open aborts that frame, then the word
        // starts afresh exactly as it would from IDLE.
        if (state_reg == ACCUM) begin
          err_next = 1'b1;
        end
        if (bus.last) begin
          zero_next     = wz;
          word_cnt_next = CNT_W'(1);
          nz_cnt_next   = wnz_cnt;
          done_next     = 1'b1;
          acc_z_next    = 1'b0;
          acc_cnt_next  = '0;
          acc_nz_next   = '0;
        end else begin
          acc_z_next    = wz;
          acc_cnt_next  = CNT_W'(1);
          acc_nz_next   = wnz_cnt;
        end
      end else if (state_reg == IDLE) begin
        // Continuation word with no open frame: dropped, flagged.
        err_next = 1'b1;
      end else if (bus.last) begin
        zero_next     = acc_z_reg & wz;
        word_cnt_next = cnt_inc;
        nz_cnt_next   = nz_inc;
        done_next     = 1'b1;
        acc_z_next    = 1'b0;
        acc_cnt_next  = '0;
        acc_nz_next   = '0;
      end else if (cnt_inc == CNT_W'(MAX_WORDS)) begin
        // The frame would need more than MAX_WORDS words; drop it.
        err_next      = 1'b1;
        acc_z_next    = 1'b0;
        acc_cnt_next  = '0;
        acc_nz_next   = '0;
      end else begin
        acc_z_next    = acc_z_reg & wz;
        acc_cnt_next  = cnt_inc;
        acc_nz_next   = nz_inc;
      end
    end
  end

  // Datapath registers: accumulators, published result and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_z_reg    <= 1'b0;
      acc_cnt_reg  <= '0;
      acc_nz_reg   <= '0;
      zero_reg     <= 1'b0;
      word_cnt_reg <= '0;
      nz_cnt_reg   <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      acc_z_reg    <= acc_z_next;
      acc_cnt_reg  <= acc_cnt_next;
      acc_nz_reg   <= acc_nz_next;
      zero_reg     <= zero_next;
      word_cnt_reg <= word_cnt_next;
      nz_cnt_reg   <= nz_cnt_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign bus.busy     = (state_reg == ACCUM);
  assign bus.done     = done_reg;
  assign bus.zero     = zero_reg;
  assign bus.word_cnt = word_cnt_reg;
  assign bus.nz_cnt   = nz_cnt_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_zero_chain_detect.sv
// Bench for zero_chain_detect: three instances (WIDTH 1, 8, 32) share one framed
// stimulus stream; a frame-level model predicts every output every cycle, and
// literal expectations pin key points of the stream.
module tb_zero_chain_detect;

  localparam int MAXW  = 4;
  localparam int CNT_W = $clog2(MAXW + 1);

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   n_vec;
  int   n_fail;

  zero_chain_detect_if #(.WIDTH(1),  .MAX_WORDS(MAXW)) if1 ();
  zero_chain_detect_if #(.WIDTH(8),  .MAX_WORDS(MAXW)) if8 ();
  zero_chain_detect_if #(.WIDTH(32), .MAX_WORDS(MAXW)) if32 ();

  zero_chain_detect #(.WIDTH(1),  .MAX_WORDS(MAXW)) u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  zero_chain_detect #(.WIDTH(8),  .MAX_WORDS(MAXW)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  zero_chain_detect #(.WIDTH(32), .MAX_WORDS(MAXW)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-instance actual outputs, index 0:W1 1:W8 2:W32
  logic [2:0]       act_busy, act_done, act_zero, act_err;
  logic [CNT_W-1:0] act_wc [3];
  logic [CNT_W-1:0] act_nz [3];
  assign act_busy = {if32.busy, if8.busy, if1.busy};
  assign act_done = {if32.done, if8.done, if1.done};
  assign act_zero = {if32.zero, if8.zero, if1.zero};
  assign act_err  = {if32.err,  if8.err,  if1.err};
  assign act_wc[0] = if1.word_cnt;
  assign act_wc[1] = if8.word_cnt;
  assign act_wc[2] = if32.word_cnt;
  assign act_nz[0] = if1.nz_cnt;
  assign act_nz[1] = if8.nz_cnt;
  assign act_nz[2] = if32.nz_cnt;

  task automatic check(input string name, input int w, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (W%0d) t=%0t: got %0h, required %0h", name, w, $time, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // Each queue entry holds the word-is-zero bit for the three instances.
  logic [2:0]       frame_q [$];
  logic [2:0]       e_busy, e_done, e_zero, e_err;
  logic [CNT_W-1:0] e_wc [3];
  logic [CNT_W-1:0] e_nz [3];

  task automatic publish();
    for (int k = 0; k < 3; k++) begin
      int nz;
      nz = 0;
      foreach (frame_q[i]) if (!frame_q[i][k]) nz++;
      e_wc[k]   = CNT_W'(frame_q.size());
      e_nz[k]   = CNT_W'(nz);
      e_zero[k] = (nz == 0);
      e_done[k] = 1'b1;
    end
    frame_q.delete();
  endtask

  initial begin
    e_busy = '0; e_done = '0; e_zero = '0; e_err = '0;
    for (int k = 0; k < 3; k++) begin e_wc[k] = '0; e_nz[k] = '0; end
    forever begin
      logic [2:0] w;
      @(posedge clk);
      w = {(if32.a == 32'd0), (if8.a == 8'd0), (if1.a == 1'b0)};
      e_done = '0;
      e_err  = '0;
      if (!rst_n) begin
        frame_q.delete();
        e_zero = '0;
        for (int k = 0; k < 3; k++) begin e_wc[k] = '0; e_nz[k] = '0; end
      end else if (if8.valid) begin
        if (if8.first) begin
          if (frame_q.size() != 0) begin
            e_err = '1;
            frame_q.delete();
          end
          frame_q.push_back(w);
          if (if8.last) publish();
        end else if (frame_q.size() == 0) begin
          e_err = '1;
        end else begin
          frame_q.push_back(w);
          if (if8.last) publish();
          else if (frame_q.size() >= MAXW) begin
            e_err = '1;
            frame_q.delete();
          end
        end
      end
      e_busy = (frame_q.size() != 0) ? 3'b111 : 3'b000;
    end
  end

  // ---------------- every-cycle compare ----------------
  initial begin
    int wid [3];
    wid[0] = 1; wid[1] = 8; wid[2] = 32;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          check("busy",     wid[k], 32'(act_busy[k]), 32'(e_busy[k]));
          check("done",     wid[k], 32'(act_done[k]), 32'(e_done[k]));
          check("zero",     wid[k], 32'(act_zero[k]), 32'(e_zero[k]));
          check("err",      wid[k], 32'(act_err[k]),  32'(e_err[k]));
          check("word_cnt", wid[k], 32'(act_wc[k]),   32'(e_wc[k]));
          check("nz_cnt",   wid[k], 32'(act_nz[k]),   32'(e_nz[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Presents one word for exactly one clock; returns at the next falling edge
  // where the registered results of that word are visible.
  task automatic drive(input logic v, input logic f, input logic l, input logic [31:0] d);
    if1.valid = v;  if1.first = f;  if1.last = l;  if1.a  = |d;
    if8.valid = v;  if8.first = f;  if8.last = l;  if8.a  = d[7:0];
    if32.valid = v; if32.first = f; if32.last = l; if32.a = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // W8 status pin: done, zero, word_cnt, nz_cnt, err, busy
  task automatic pin8(input string tag, input logic d, input logic z, input int wc,
                      input int nz, input logic er, input logic b);
    check({tag, ".done"},     8, 32'(if8.done),     32'(d));
    check({tag, ".zero"},     8, 32'(if8.zero),     32'(z));
    check({tag, ".word_cnt"}, 8, 32'(if8.word_cnt), 32'(wc));
    check({tag, ".nz_cnt"},   8, 32'(if8.nz_cnt),   32'(nz));
    check({tag, ".err"},      8, 32'(if8.err),      32'(er));
    check({tag, ".busy"},     8, 32'(if8.busy),     32'(b));
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    if1.valid = 1'b0;  if1.first = 1'b0;  if1.last = 1'b0;  if1.a = '0;
    if8.valid = 1'b0;  if8.first = 1'b0;  if8.last = 1'b0;  if8.a = '0;
    if32.valid = 1'b0; if32.first = 1'b0; if32.last = 1'b0; if32.a = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    pin8("reset", 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle();

    // single-word operations
    drive(1, 1, 1, 32'h00);  pin8("single00", 1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 32'hAA);  pin8("singleAA", 1, 0, 1, 1, 0, 0);
    idle();
    pin8("hold", 0, 0, 1, 1, 0, 0);

    // 3-word all-zero frame
    drive(1, 1, 0, 32'h00);  check("f3.busy", 8, 32'(if8.busy), 32'd1);
    drive(1, 0, 0, 32'h00);
    drive(1, 0, 1, 32'h00);  pin8("f3zero", 1, 1, 3, 0, 0, 0);

    // 3-word frame with one non-zero word, then back-to-back single word
    drive(1, 1, 0, 32'h00);
    drive(1, 0, 0, 32'h01);
    drive(1, 0, 1, 32'h00);  pin8("f3nz", 1, 0, 3, 1, 0, 0);
    drive(1, 1, 1, 32'h00);  pin8("b2b", 1, 1, 1, 0, 0, 0);
    idle();

    // 5-word frame: overflow on word 4, orphan last on word 5
    drive(1, 1, 0, 32'h00);
    drive(1, 0, 0, 32'h00);
    drive(1, 0, 0, 32'h00);  check("ovf.busy3", 8, 32'(if8.busy), 32'd1);
    drive(1, 0, 0, 32'h00);  pin8("ovf4", 0, 1, 1, 0, 1, 0);
    drive(1, 0, 1, 32'h00);  pin8("ovf5", 0, 1, 1, 0, 1, 0);
    idle();

    // continuation word with no open frame
    drive(1, 0, 0, 32'h55);  pin8("orphan", 0, 1, 1, 0, 1, 0);
    idle();

    // abort open frame with a single-word op
    drive(1, 1, 0, 32'h00);
    drive(1, 0, 0, 32'h10);
    drive(1, 1, 1, 32'h00);  pin8("abort", 1, 1, 1, 0, 1, 0);
    idle();

    // reset in the middle of a frame, then a normal frame
    drive(1, 1, 0, 32'h00);
    drive(1, 0, 0, 32'h00);
    rst_n = 1'b0;
    drive(1, 0, 1, 32'h00);  pin8("midrst", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(1, 1, 0, 32'h03);
    drive(1, 0, 1, 32'h00);  pin8("postrst", 1, 0, 2, 1, 0, 0);

    // high-bit-only word: non-zero only for the 32-bit instance (and W1)
    drive(1, 1, 1, 32'h8000_0000);
    check("msb.zero", 32, 32'(if32.zero),   32'd0);
    check("msb.nz",   32, 32'(if32.nz_cnt), 32'd1);
    check("msb.zero",  8, 32'(if8.zero),    32'd1);
    check("msb.zero",  1, 32'(if1.zero),    32'd0);
    idle();

    // legal frame of exactly MAX_WORDS with idle gaps inside ACCUM
    drive(1, 1, 0, 32'h00);
    idle();
    idle();                  check("gap.busy", 8, 32'(if8.busy), 32'd1);
    drive(1, 0, 0, 32'h00);
    drive(1, 0, 0, 32'h00);
    drive(1, 0, 1, 32'h00);  pin8("max4", 1, 1, 4, 0, 0, 0);

    // 4-word frame with non-zero words on the 1-bit path
    drive(1, 1, 0, 32'h01);
    drive(1, 0, 0, 32'h00);
    drive(1, 0, 0, 32'h01);
    drive(1, 0, 1, 32'h00);
    check("w1.zero", 1, 32'(if1.zero),   32'd0);
    check("w1.nz",   1, 32'(if1.nz_cnt), 32'd2);
    check("w1.wc",   1, 32'(if1.word_cnt), 32'd4);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
